// File: rtl/uc_multiciclo.sv
// uc_multiciclo: multicycle MIPS control unit, a Moore FSM with MEM_LAT memory wait-states.
// Define UC_MULTI_JUMP_EN to support the j instruction (opcode 000010); otherwise j is illegal.
module uc_multiciclo #(
    parameter int OPCODE_W = 6,
    parameter int MEM_LAT  = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [OPCODE_W-1:0] opcode,
    output logic                pcWrite,
    output logic                pcWriteCond,
    output logic                iorD,
    output logic                memRead,
    output logic                memWrite,
    output logic                irWrite,
    output logic                memtoReg,
    output logic                regDst,
    output logic                regWrite,
    output logic                aluSrcA,
    output logic [1:0]          aluSrcB,
    output logic [1:0]          aluOp,
    output logic [1:0]          pcSrc,
    output logic                illegalOp,
    output logic [3:0]          state
);
    localparam logic [3:0] S_RST    = 4'd0;
    localparam logic [3:0] S_FETCH  = 4'd1;
    localparam logic [3:0] S_DECODE = 4'd2;
    localparam logic [3:0] S_MEMADR = 4'd3;
    localparam logic [3:0] S_MEMRD  = 4'd4;
    localparam logic [3:0] S_MEMWB  = 4'd5;
    localparam logic [3:0] S_MEMWR  = 4'd6;
    localparam logic [3:0] S_EXEC   = 4'd7;
    localparam logic [3:0] S_ALUWB  = 4'd8;
    localparam logic [3:0] S_BRANCH = 4'd9;
    localparam logic [3:0] S_ADDIEX = 4'd10;
    localparam logic [3:0] S_ADDIWB = 4'd11;
    localparam logic [3:0] S_JUMP   = 4'd12;

    localparam logic [OPCODE_W-1:0] OP_R    = OPCODE_W'(6'b000000);
    localparam logic [OPCODE_W-1:0] OP_LW   = OPCODE_W'(6'b100011);
    localparam logic [OPCODE_W-1:0] OP_SW   = OPCODE_W'(6'b101011);
    localparam logic [OPCODE_W-1:0] OP_BEQ  = OPCODE_W'(6'b000100);
    localparam logic [OPCODE_W-1:0] OP_ADDI = OPCODE_W'(6'b001000);
`ifdef UC_MULTI_JUMP_EN
    localparam logic [OPCODE_W-1:0] OP_J    = OPCODE_W'(6'b000010);
`endif
    localparam logic [3:0] LAST_WAIT = 4'(MEM_LAT);

    logic [3:0] r_state;
    logic [3:0] r_wait_cnt;
    logic [3:0] w_next;
    logic [3:0] w_dec;
    logic [3:0] w_wait_nxt;
    logic       w_last;
    logic       w_wait_st;
    logic       w_legal;

    // memory states stretch to MEM_LAT+1 cycles; the counter restarts on every exit
    assign w_last     = r_wait_cnt == LAST_WAIT;
    assign w_wait_st  = r_state inside {S_FETCH, S_MEMRD, S_MEMWR};
    assign w_wait_nxt = (w_wait_st && !w_last) ? r_wait_cnt + 4'd1 : 4'd0;
    assign state      = r_state;

    // state and wait counter; reset aborts any instruction in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_RST;
            r_wait_cnt <= 4'd0;
        end else begin
            r_state    <= w_next;
            r_wait_cnt <= w_wait_nxt;
        end
    end

    // opcode dispatch used when leaving DECODE; unknown opcodes fall back to FETCH
    always_comb begin
        w_dec   = S_FETCH;
        w_legal = 1'b1;
        if (opcode == OP_R) w_dec = S_EXEC;
        else if (opcode == OP_LW || opcode == OP_SW) w_dec = S_MEMADR;
        else if (opcode == OP_BEQ) w_dec = S_BRANCH;
        else if (opcode == OP_ADDI) w_dec = S_ADDIEX;
`ifdef UC_MULTI_JUMP_EN
        else if (opcode == OP_J) w_dec = S_JUMP;
`endif
        else w_legal = 1'b0;
    end

    // next-state sequencing; unused encodings recover to FETCH
    always_comb begin
        w_next = S_FETCH;
        case (r_state)
            S_FETCH:  w_next = w_last ? S_DECODE : S_FETCH;
            S_DECODE: w_next = w_dec;
            S_MEMADR: w_next = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  w_next = w_last ? S_MEMWB : S_MEMRD;
            S_MEMWR:  w_next = w_last ? S_FETCH : S_MEMWR;
            S_EXEC:   w_next = S_ALUWB;
            S_ADDIEX: w_next = S_ADDIWB;
            default:  w_next = S_FETCH;
        endcase
    end

    // datapath controls decoded from state; illegalOp is the only opcode-dependent output
    always_comb begin
        pcWrite     = 1'b0;
        pcWriteCond = 1'b0;
        iorD        = 1'b0;
        memRead     = 1'b0;
        memWrite    = 1'b0;
        irWrite     = 1'b0;
        memtoReg    = 1'b0;
        regDst      = 1'b0;
        regWrite    = 1'b0;
        aluSrcA     = 1'b0;
        aluSrcB     = 2'b00;
        aluOp       = 2'b00;
        pcSrc       = 2'b00;
        illegalOp   = 1'b0;
        case (r_state)
            S_FETCH: begin
                memRead = 1'b1;
                aluSrcB = 2'b01;
                irWrite = w_last;
                pcWrite = w_last;
            end
            S_DECODE: begin
                aluSrcB   = 2'b11;
                illegalOp = !w_legal;
            end
            S_MEMADR, S_ADDIEX: begin
                aluSrcA = 1'b1;
                aluSrcB = 2'b10;
            end
            S_MEMRD: begin
                memRead = 1'b1;
                iorD    = 1'b1;
            end
            S_MEMWB: begin
                regWrite = 1'b1;
                memtoReg = 1'b1;
            end
            S_MEMWR: begin
                memWrite = 1'b1;
                iorD     = 1'b1;
            end
            S_EXEC: begin
                aluSrcA = 1'b1;
                aluOp   = 2'b10;
            end
            S_ALUWB: begin
                regWrite = 1'b1;
                regDst   = 1'b1;
            end
            S_BRANCH: begin
                aluSrcA     = 1'b1;
                aluOp       = 2'b01;
                pcWriteCond = 1'b1;
                pcSrc       = 2'b01;
            end
            S_ADDIWB: regWrite = 1'b1;
            S_JUMP: begin
                pcWrite = 1'b1;
                pcSrc   = 2'b10;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_uc_multiciclo.sv
// tb_uc_multiciclo: randomized instruction stream checked cycle by cycle against a per-instruction state/output plan.
module tb_uc_multiciclo;
    localparam int LAT = 2;
`ifdef UC_MULTI_JUMP_EN
    localparam bit JEN = 1'b1;
`else
    localparam bit JEN = 1'b0;
`endif
    localparam logic [5:0] OPS [7] = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000, 6'b000010, 6'b111111};

    typedef struct packed {
        logic       pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, srca;
        logic [1:0] srcb, aluop, pcsrc;
        logic       ill;
    } outs_t;
    typedef struct {
        int st;
        bit last;
        bit ill;
    } step_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] opcode = 6'd0;
    logic       pcWrite, pcWriteCond, iorD, memRead, memWrite, irWrite, memtoReg, regDst, regWrite, aluSrcA, illegalOp;
    logic [1:0] aluSrcB, aluOp, pcSrc;
    logic [3:0] state;
    outs_t      act;
    step_t      plan[$];
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    assign act = {pcWrite, pcWriteCond, iorD, memRead, memWrite, irWrite, memtoReg, regDst, regWrite, aluSrcA, aluSrcB, aluOp, pcSrc, illegalOp};

    uc_multiciclo #(.OPCODE_W(6), .MEM_LAT(LAT)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode),
        .pcWrite(pcWrite), .pcWriteCond(pcWriteCond), .iorD(iorD), .memRead(memRead),
        .memWrite(memWrite), .irWrite(irWrite), .memtoReg(memtoReg), .regDst(regDst),
        .regWrite(regWrite), .aluSrcA(aluSrcA), .aluSrcB(aluSrcB), .aluOp(aluOp),
        .pcSrc(pcSrc), .illegalOp(illegalOp), .state(state)
    );

    function automatic bit is_legal(input logic [5:0] op);
        return op inside {6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000} || (JEN && op == 6'b000010);
    endfunction

    function automatic outs_t expect_outs(input step_t s);
        outs_t o = '0;
        case (s.st)
            1: begin o.mrd = 1; o.srcb = 2'b01; o.irw = s.last; o.pcw = s.last; end
            2: begin o.srcb = 2'b11; o.ill = s.ill; end
            3, 10: begin o.srca = 1; o.srcb = 2'b10; end
            4: begin o.mrd = 1; o.iord = 1; end
            5: begin o.rw = 1; o.m2r = 1; end
            6: begin o.mwr = 1; o.iord = 1; end
            7: begin o.srca = 1; o.aluop = 2'b10; end
            8: begin o.rw = 1; o.rdst = 1; end
            9: begin o.srca = 1; o.aluop = 2'b01; o.pcwc = 1; o.pcsrc = 2'b01; end
            11: o.rw = 1;
            12: begin o.pcw = 1; o.pcsrc = 2'b10; end
            default: ;
        endcase
        return o;
    endfunction

    function automatic void push(input int st, input int n);
        for (int i = 0; i < n; i++) plan.push_back('{st, i == n - 1, 1'b0});
    endfunction

    // expected state sequence for one instruction, FETCH up to the next FETCH
    function automatic void build(input logic [5:0] op);
        plan.delete();
        push(1, LAT + 1);
        plan.push_back('{2, 1'b1, !is_legal(op)});
        if (is_legal(op)) begin
            case (op)
                6'b000000: begin push(7, 1); push(8, 1); end
                6'b100011: begin push(3, 1); push(4, LAT + 1); push(5, 1); end
                6'b101011: begin push(3, 1); push(6, LAT + 1); end
                6'b000100: push(9, 1);
                6'b001000: begin push(10, 1); push(11, 1); end
                default: push(12, 1);
            endcase
        end
    endfunction

    // runs one instruction from its first FETCH cycle; opcode is junk until DECODE
    task automatic test_instruction(input logic [5:0] op);
        build(op);
        foreach (plan[i]) begin
            opcode = (plan[i].st == 1) ? 6'($urandom) : op;
            #1;
            checks++;
            if (state !== 4'(plan[i].st)) begin
                errors++;
                $display("FAIL state op=%b step %0d: got %0d want %0d", op, i, state, plan[i].st);
            end
            checks++;
            if (act !== expect_outs(plan[i])) begin
                errors++;
                $display("FAIL outs op=%b step %0d state %0d: got %b want %b", op, i, plan[i].st, act, expect_outs(plan[i]));
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset;
        @(posedge clk); #1;
        checks++;
        if (state !== 4'd0 || act !== '0) begin
            errors++;
            $display("FAIL reset_hold: got state %0d outs %b want 0", state, act);
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (state !== 4'd0) begin
            errors++;
            $display("FAIL reset_release: got %0d want 0", state);
        end
        @(posedge clk); #1;
        checks++;
        if (state !== 4'd1) begin
            errors++;
            $display("FAIL first_fetch: got %0d want 1", state);
        end
    endtask

    task automatic test_opcodes;
        foreach (OPS[k]) test_instruction(OPS[k]);
    endtask

    task automatic test_reset_mid;
        opcode = 6'b000000;
        repeat (LAT + 2) @(posedge clk);
        #1;
        checks++;
        if (state !== 4'd7) begin
            errors++;
            $display("FAIL reach_exec: got %0d want 7", state);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (state !== 4'd0 || act !== '0) begin
            errors++;
            $display("FAIL async_reset: got state %0d outs %b want 0", state, act);
        end
        @(posedge clk); #1;
        checks++;
        if (state !== 4'd0 || act !== '0) begin
            errors++;
            $display("FAIL reset_held: got state %0d outs %b want 0", state, act);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        test_instruction(6'b000000);
    endtask

    task automatic test_back_to_back;
        for (int n = 0; n < 40; n++) begin
            int k = $urandom_range(0, 8);
            test_instruction(k < 7 ? OPS[k] : 6'($urandom_range(0, 63)));
        end
    endtask

    initial begin
        test_reset;
        test_opcodes;
        test_reset_mid;
        test_back_to_back;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
